// File: rtl/controle_pontuacao.sv
// Round scorer: five-state FSM turns (round, error count) into points, accumulates a saturating score and tracks the record.
// pronto pulses in the 4th cycle after an accepted fim_rodada; requests while ocupado are dropped, never queued.
module controle_pontuacao #(
  parameter logic [7:0] PONTOS_MAX = 8'd255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zera,
  input  logic       registra_erro,
  input  logic       fim_rodada,
  input  logic [3:0] rodada,
  output logic [7:0] erros_rodada,
  output logic [7:0] ganho,
  output logic [7:0] pontos,
  output logic [7:0] recorde,
  output logic       ocupado,
  output logic       pronto,
  output logic       novo_recorde
);

  typedef enum logic [2:0] {
    OCIOSO,
    CAPTURA,
    SUBTRAI,
    ACUMULA,
    FINALIZA
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [3:0] rodada_q, rodada_d;
  logic [7:0] snap_q, snap_d;
  logic [3:0] base_q, base_d;
  logic [7:0] ganho_q, ganho_d;
  logic [7:0] pontos_q, pontos_d;
  logic [7:0] recorde_q, recorde_d;
  logic [7:0] erros_q, erros_d;
  logic       ocupado_q, ocupado_d;
  logic       pronto_q, pronto_d;
  logic       novo_q, novo_d;

  logic [8:0] soma;
  logic [7:0] pontos_sat;
  logic [7:0] erros_inc;

  always_comb begin
    estado_d   = estado_q;
    rodada_d   = rodada_q;
    snap_d     = snap_q;
    base_d     = base_q;
    ganho_d    = ganho_q;
    pontos_d   = pontos_q;
    recorde_d  = recorde_q;
    ocupado_d  = ocupado_q;
    pronto_d   = 1'b0;
    novo_d     = 1'b0;

    // Nine-bit sum so a large score plus gain cannot wrap before saturation.
    soma       = {1'b0, pontos_q} + {1'b0, ganho_q};
    pontos_sat = (soma > {1'b0, PONTOS_MAX}) ? PONTOS_MAX : soma[7:0];
    erros_inc  = (registra_erro && (erros_q != 8'hFF)) ? erros_q + 8'd1 : erros_q;
    erros_d    = erros_inc;

    if (zera) begin
      estado_d  = OCIOSO;
      pontos_d  = 8'd0;
      ganho_d   = 8'd0;
      erros_d   = 8'd0;
      ocupado_d = 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (fim_rodada) begin
            estado_d  = CAPTURA;
            rodada_d  = rodada;
            snap_d    = erros_inc;
            erros_d   = 8'd0;
            ocupado_d = 1'b1;
          end
        end
        CAPTURA: begin
          if (rodada_q == 4'd0)      base_d = 4'd1;
          else if (rodada_q > 4'd9)  base_d = 4'd9;
          else                       base_d = rodada_q;
          estado_d = SUBTRAI;
        end
        SUBTRAI: begin
          ganho_d  = (snap_q < {4'b0, base_q}) ? ({4'b0, base_q} - snap_q) : 8'd0;
          estado_d = ACUMULA;
        end
        ACUMULA: begin
          pontos_d = pontos_sat;
          if (pontos_sat > recorde_q) begin
            recorde_d = pontos_sat;
            novo_d    = 1'b1;
          end
          pronto_d = 1'b1;
          estado_d = FINALIZA;
        end
        FINALIZA: begin
          estado_d  = OCIOSO;
          ocupado_d = 1'b0;
        end
        default: begin
          estado_d  = OCIOSO;
          ocupado_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      rodada_q  <= 4'd0;
      snap_q    <= 8'd0;
      base_q    <= 4'd0;
      ganho_q   <= 8'd0;
      pontos_q  <= 8'd0;
      recorde_q <= 8'd0;
      erros_q   <= 8'd0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      novo_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      rodada_q  <= rodada_d;
      snap_q    <= snap_d;
      base_q    <= base_d;
      ganho_q   <= ganho_d;
      pontos_q  <= pontos_d;
      recorde_q <= recorde_d;
      erros_q   <= erros_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
      novo_q    <= novo_d;
    end
  end

  assign erros_rodada = erros_q;
  assign ganho        = ganho_q;
  assign pontos       = pontos_q;
  assign recorde      = recorde_q;
  assign ocupado      = ocupado_q;
  assign pronto       = pronto_q;
  assign novo_recorde = novo_q;

endmodule
